// File: rtl/dram_axi_id_remap.sv
// Compresses wide SoC AXI IDs onto the DRAM controller's narrow ID space and restores them on B/R.
// Each direction has its own tracking table. The datapath is combinational; only the tables hold state.

module dram_axi_id_remap_table #(
   parameter int unsigned IdWidth  = 6,
   parameter int unsigned MidWidth = 4,
   parameter int unsigned MaxTxns  = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [IdWidth-1:0]  req_id,
   input  logic                req_fire,
   output logic                req_stall,
   output logic [MidWidth-1:0] req_mid,
   input  logic                rsp_fire,
   input  logic                rsp_done,
   input  logic [MidWidth-1:0] rsp_mid,
   output logic [IdWidth-1:0]  rsp_id
);
   localparam int unsigned NumEntries = 2 ** MidWidth;
   localparam int unsigned CntWidth   = $clog2(MaxTxns + 1);

   logic [NumEntries-1:0] valid_q, valid_d;
   logic [NumEntries-1:0] inc, dec;
   logic [CntWidth-1:0]   cnt_q [NumEntries];
   logic [CntWidth-1:0]   cnt_d [NumEntries];
   logic [IdWidth-1:0]    sid_q [NumEntries];
   logic                  hit, free_found;
   logic [MidWidth-1:0]   hit_idx, free_idx;

   // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
   always_comb begin
      hit        = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < NumEntries; i++) begin
         if (valid_q[i] && (sid_q[i] == req_id) && !hit) begin
            hit     = 1'b1;
            hit_idx = MidWidth'(i);
         end
         if (!valid_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = MidWidth'(i);
         end
      end
   end

   // Stall depends only on registered table state, never on the downstream ready.
   assign req_mid   = hit ? hit_idx : free_idx;
   assign req_stall = hit ? (cnt_q[hit_idx] == CntWidth'(MaxTxns)) : !free_found;
   assign rsp_id    = valid_q[rsp_mid] ? sid_q[rsp_mid] : '0;

   always_comb begin
      inc = '0;
      dec = '0;
      for (int i = 0; i < NumEntries; i++) begin
         inc[i] = req_fire && (req_mid == MidWidth'(i));
         dec[i] = rsp_fire && rsp_done && valid_q[i] && (rsp_mid == MidWidth'(i));
      end
   end

   // Request and completion on the same entry cancel; an entry leaves the table when cnt hits 0.
   always_comb begin
      valid_d = '0;
      cnt_d   = cnt_q;
      for (int i = 0; i < NumEntries; i++) begin
         cnt_d[i]   = cnt_q[i] + CntWidth'(inc[i]) - CntWidth'(dec[i]);
         valid_d[i] = (cnt_d[i] != '0);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= '0;
         for (int i = 0; i < NumEntries; i++) cnt_q[i] <= '0;
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: the SID store needs no reset; it is only ever read through a cleared valid bit.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NumEntries; i++) begin
         if (inc[i] && !valid_q[i]) sid_q[i] <= req_id;
      end
   end

   // A response on an untracked DRAM ID means the table and the MIG disagree (e.g. reset mid-burst).
   a_rsp_tracked : assert property (@(posedge clk_i) disable iff (!rst_ni)
      rsp_fire |-> valid_q[rsp_mid]);
endmodule

module dram_axi_id_remap #(
   parameter int unsigned SlvIdWidth   = 6,
   parameter int unsigned MstIdWidth   = 4,
   parameter int unsigned MaxTxnsPerId = 8,
   parameter int unsigned AxPldWidth   = 47,
   parameter int unsigned DataWidth    = 64,
   parameter int unsigned UserWidth    = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   // SoC side (from spill register)
   input  logic                   slv_aw_valid,
   output logic                   slv_aw_ready,
   input  logic [SlvIdWidth-1:0]  slv_aw_id,
   input  logic [AxPldWidth-1:0]  slv_aw_pld,
   input  logic                   slv_w_valid,
   output logic                   slv_w_ready,
   input  logic [DataWidth-1:0]   slv_w_data,
   input  logic [DataWidth/8-1:0] slv_w_strb,
   input  logic                   slv_w_last,
   output logic                   slv_b_valid,
   input  logic                   slv_b_ready,
   output logic [SlvIdWidth-1:0]  slv_b_id,
   output logic [1:0]             slv_b_resp,
   output logic [UserWidth-1:0]   slv_b_user,
   input  logic                   slv_ar_valid,
   output logic                   slv_ar_ready,
   input  logic [SlvIdWidth-1:0]  slv_ar_id,
   input  logic [AxPldWidth-1:0]  slv_ar_pld,
   output logic                   slv_r_valid,
   input  logic                   slv_r_ready,
   output logic [SlvIdWidth-1:0]  slv_r_id,
   output logic [DataWidth-1:0]   slv_r_data,
   output logic [1:0]             slv_r_resp,
   output logic                   slv_r_last,
   output logic [UserWidth-1:0]   slv_r_user,
   // DRAM side (to MIG)
   output logic                   mst_aw_valid,
   input  logic                   mst_aw_ready,
   output logic [MstIdWidth-1:0]  mst_aw_id,
   output logic [AxPldWidth-1:0]  mst_aw_pld,
   output logic                   mst_w_valid,
   input  logic                   mst_w_ready,
   output logic [DataWidth-1:0]   mst_w_data,
   output logic [DataWidth/8-1:0] mst_w_strb,
   output logic                   mst_w_last,
   input  logic                   mst_b_valid,
   output logic                   mst_b_ready,
   input  logic [MstIdWidth-1:0]  mst_b_id,
   input  logic [1:0]             mst_b_resp,
   output logic                   mst_ar_valid,
   input  logic                   mst_ar_ready,
   output logic [MstIdWidth-1:0]  mst_ar_id,
   output logic [AxPldWidth-1:0]  mst_ar_pld,
   input  logic                   mst_r_valid,
   output logic                   mst_r_ready,
   input  logic [MstIdWidth-1:0]  mst_r_id,
   input  logic [DataWidth-1:0]   mst_r_data,
   input  logic [1:0]             mst_r_resp,
   input  logic                   mst_r_last
);
   logic aw_stall, ar_stall;

   // Reset holds back new address requests; W, B and R keep flowing.
   assign mst_aw_valid = rst_ni && slv_aw_valid && !aw_stall;
   assign slv_aw_ready = rst_ni && mst_aw_ready && !aw_stall;
   assign mst_aw_pld   = slv_aw_pld;
   assign mst_ar_valid = rst_ni && slv_ar_valid && !ar_stall;
   assign slv_ar_ready = rst_ni && mst_ar_ready && !ar_stall;
   assign mst_ar_pld   = slv_ar_pld;

   assign mst_w_valid  = slv_w_valid;
   assign slv_w_ready  = mst_w_ready;
   assign mst_w_data   = slv_w_data;
   assign mst_w_strb   = slv_w_strb;
   assign mst_w_last   = slv_w_last;

   assign slv_b_valid  = mst_b_valid;
   assign mst_b_ready  = slv_b_ready;
   assign slv_b_resp   = mst_b_resp;
   assign slv_b_user   = '0;
   assign slv_r_valid  = mst_r_valid;
   assign mst_r_ready  = slv_r_ready;
   assign slv_r_data   = mst_r_data;
   assign slv_r_resp   = mst_r_resp;
   assign slv_r_last   = mst_r_last;
   assign slv_r_user   = '0;

   dram_axi_id_remap_table #(
      .IdWidth  (SlvIdWidth),
      .MidWidth (MstIdWidth),
      .MaxTxns  (MaxTxnsPerId)
   ) u_wr_table (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_id    (slv_aw_id),
      .req_fire  (mst_aw_valid && mst_aw_ready),
      .req_stall (aw_stall),
      .req_mid   (mst_aw_id),
      .rsp_fire  (mst_b_valid && slv_b_ready),
      .rsp_done  (1'b1),
      .rsp_mid   (mst_b_id),
      .rsp_id    (slv_b_id)
   );

   // Only the last beat of a read burst retires the transaction.
   dram_axi_id_remap_table #(
      .IdWidth  (SlvIdWidth),
      .MidWidth (MstIdWidth),
      .MaxTxns  (MaxTxnsPerId)
   ) u_rd_table (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_id    (slv_ar_id),
      .req_fire  (mst_ar_valid && mst_ar_ready),
      .req_stall (ar_stall),
      .req_mid   (mst_ar_id),
      .rsp_fire  (mst_r_valid && slv_r_ready),
      .rsp_done  (mst_r_last),
      .rsp_mid   (mst_r_id),
      .rsp_id    (slv_r_id)
   );
endmodule

// File: tb/tb_dram_axi_id_remap.sv
// Bench for dram_axi_id_remap: vector table, directed corner sequences, then random traffic
// checked against an associative-array model of SoC-ID ownership.

module tb_dram_axi_id_remap;
   localparam int SID = 6;
   localparam int MID = 4;
   localparam int MAXT = 8;
   localparam int AXW = 47;
   localparam int DW = 64;
   localparam int UW = 1;

   logic clk, rst_ni;
   logic slv_aw_valid, slv_aw_ready, slv_w_valid, slv_w_ready, slv_w_last;
   logic slv_b_valid, slv_b_ready, slv_ar_valid, slv_ar_ready, slv_r_valid, slv_r_ready, slv_r_last;
   logic [SID-1:0] slv_aw_id, slv_b_id, slv_ar_id, slv_r_id;
   logic [AXW-1:0] slv_aw_pld, slv_ar_pld, mst_aw_pld, mst_ar_pld;
   logic [DW-1:0] slv_w_data, slv_r_data, mst_w_data, mst_r_data;
   logic [DW/8-1:0] slv_w_strb, mst_w_strb;
   logic [1:0] slv_b_resp, slv_r_resp, mst_b_resp, mst_r_resp;
   logic [UW-1:0] slv_b_user, slv_r_user;
   logic mst_aw_valid, mst_aw_ready, mst_w_valid, mst_w_ready, mst_w_last;
   logic mst_b_valid, mst_b_ready, mst_ar_valid, mst_ar_ready, mst_r_valid, mst_r_ready, mst_r_last;
   logic [MID-1:0] mst_aw_id, mst_b_id, mst_ar_id, mst_r_id;

   int errors = 0;
   int checks = 0;

   dram_axi_id_remap #(
      .SlvIdWidth(SID), .MstIdWidth(MID), .MaxTxnsPerId(MAXT),
      .AxPldWidth(AXW), .DataWidth(DW), .UserWidth(UW)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .slv_aw_valid(slv_aw_valid), .slv_aw_ready(slv_aw_ready), .slv_aw_id(slv_aw_id), .slv_aw_pld(slv_aw_pld),
      .slv_w_valid(slv_w_valid), .slv_w_ready(slv_w_ready), .slv_w_data(slv_w_data),
      .slv_w_strb(slv_w_strb), .slv_w_last(slv_w_last),
      .slv_b_valid(slv_b_valid), .slv_b_ready(slv_b_ready), .slv_b_id(slv_b_id),
      .slv_b_resp(slv_b_resp), .slv_b_user(slv_b_user),
      .slv_ar_valid(slv_ar_valid), .slv_ar_ready(slv_ar_ready), .slv_ar_id(slv_ar_id), .slv_ar_pld(slv_ar_pld),
      .slv_r_valid(slv_r_valid), .slv_r_ready(slv_r_ready), .slv_r_id(slv_r_id), .slv_r_data(slv_r_data),
      .slv_r_resp(slv_r_resp), .slv_r_last(slv_r_last), .slv_r_user(slv_r_user),
      .mst_aw_valid(mst_aw_valid), .mst_aw_ready(mst_aw_ready), .mst_aw_id(mst_aw_id), .mst_aw_pld(mst_aw_pld),
      .mst_w_valid(mst_w_valid), .mst_w_ready(mst_w_ready), .mst_w_data(mst_w_data),
      .mst_w_strb(mst_w_strb), .mst_w_last(mst_w_last),
      .mst_b_valid(mst_b_valid), .mst_b_ready(mst_b_ready), .mst_b_id(mst_b_id), .mst_b_resp(mst_b_resp),
      .mst_ar_valid(mst_ar_valid), .mst_ar_ready(mst_ar_ready), .mst_ar_id(mst_ar_id), .mst_ar_pld(mst_ar_pld),
      .mst_r_valid(mst_r_valid), .mst_r_ready(mst_r_ready), .mst_r_id(mst_r_id), .mst_r_data(mst_r_data),
      .mst_r_resp(mst_r_resp), .mst_r_last(mst_r_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic aw_v, input logic [5:0] aw_id, input logic b_v, input logic [3:0] b_mid,
                         input logic ar_v, input logic [5:0] ar_id, input logic r_v, input logic [3:0] r_mid,
                         input logic r_last);
      slv_aw_valid = aw_v;  slv_aw_id = aw_id;
      mst_b_valid  = b_v;   mst_b_id  = b_mid;
      slv_ar_valid = ar_v;  slv_ar_id = ar_id;
      mst_r_valid  = r_v;   mst_r_id  = r_mid;  mst_r_last = r_last;
      mst_aw_ready = 1'b1;  mst_ar_ready = 1'b1;
      slv_b_ready  = 1'b1;  slv_r_ready  = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct packed {
      logic       aw_v;
      logic [5:0] aw_id;
      logic       b_v;
      logic [3:0] b_mid;
      logic       ar_v;
      logic [5:0] ar_id;
      logic       r_v;
      logic [3:0] r_mid;
      logic       r_last;
      logic [3:0] e_mid;
      logic [5:0] e_sid;
   } vec_t;

   function automatic vec_t v_aw(input logic [5:0] id, input logic [3:0] mid);
      vec_t v = '0;
      v.aw_v = 1'b1; v.aw_id = id; v.e_mid = mid;
      return v;
   endfunction

   function automatic vec_t v_ar(input logic [5:0] id, input logic [3:0] mid);
      vec_t v = '0;
      v.ar_v = 1'b1; v.ar_id = id; v.e_mid = mid;
      return v;
   endfunction

   function automatic vec_t v_b(input logic [3:0] mid, input logic [5:0] sid);
      vec_t v = '0;
      v.b_v = 1'b1; v.b_mid = mid; v.e_sid = sid;
      return v;
   endfunction

   function automatic vec_t v_r(input logic [3:0] mid, input logic last, input logic [5:0] sid);
      vec_t v = '0;
      v.r_v = 1'b1; v.r_mid = mid; v.r_last = last; v.e_sid = sid;
      return v;
   endfunction

   localparam int NV = 21;
   vec_t vecs [NV];

   // ---------------- reference model ----------------
   // Key = dir*256 + SoC ID; dir 0 = write, 1 = read. An ID present in the map owns one DRAM ID.
   int mid_of [int];
   int cnt_of [int];

   function automatic int owner(input int dir, input int mid);
      int sid = -1;
      foreach (mid_of[k]) if ((k / 256 == dir) && (mid_of[k] == mid)) sid = k % 256;
      return sid;
   endfunction

   function automatic void predict(input int dir, input int sid, output bit stall, output int mid);
      int key = dir * 256 + sid;
      stall = 1'b1;
      mid   = 0;
      if (mid_of.exists(key)) begin
         mid   = mid_of[key];
         stall = (cnt_of[key] == MAXT);
      end else begin
         for (int m = 15; m >= 0; m--) begin
            if (owner(dir, m) < 0) begin
               stall = 1'b0;
               mid   = m;
            end
         end
      end
   endfunction

   function automatic void apply(input int dir, input bit req, input int sid, input int mid,
                                 input bit rsp, input int rsp_mid);
      int okey = -1;
      int key  = dir * 256 + sid;
      if (rsp) begin
         int o = owner(dir, rsp_mid);
         if (o >= 0) okey = dir * 256 + o;
      end
      if (req) begin
         if (mid_of.exists(key)) cnt_of[key] = cnt_of[key] + 1;
         else begin
            mid_of[key] = mid;
            cnt_of[key] = 1;
         end
      end
      if (okey >= 0) begin
         cnt_of[okey] = cnt_of[okey] - 1;
         if (cnt_of[okey] == 0) begin
            mid_of.delete(okey);
            cnt_of.delete(okey);
         end
      end
   endfunction

   function automatic int pick_live(input int dir);
      int q[$];
      foreach (mid_of[k]) if (k / 256 == dir) q.push_back(mid_of[k]);
      if (q.size() == 0) return -1;
      return q[$urandom_range(0, q.size() - 1)];
   endfunction

   task automatic run_random(input int n);
      bit aw_st, ar_st, aw_go, ar_go;
      int aw_m, ar_m, bm, rm, es;
      for (int c = 0; c < n; c++) begin
         rst_ni       = ($urandom_range(0, 299) != 0);
         slv_aw_valid = ($urandom_range(0, 1) != 0);
         slv_aw_id    = 6'($urandom_range(0, 19));
         mst_aw_ready = ($urandom_range(0, 3) != 0);
         slv_ar_valid = ($urandom_range(0, 1) != 0);
         slv_ar_id    = 6'($urandom_range(0, 19));
         mst_ar_ready = ($urandom_range(0, 3) != 0);
         bm           = pick_live(0);
         mst_b_valid  = (bm >= 0) && ($urandom_range(0, 99) < 45);
         mst_b_id     = 4'((bm < 0) ? 0 : bm);
         slv_b_ready  = ($urandom_range(0, 4) != 0);
         rm           = pick_live(1);
         mst_r_valid  = (rm >= 0) && ($urandom_range(0, 99) < 45);
         mst_r_id     = 4'((rm < 0) ? 0 : rm);
         mst_r_last   = ($urandom_range(0, 99) < 60);
         slv_r_ready  = ($urandom_range(0, 4) != 0);
         slv_ar_pld   = AXW'({$urandom(), $urandom()});
         slv_w_data   = {$urandom(), $urandom()};
         mst_r_data   = {$urandom(), $urandom()};
         sample();
         predict(0, int'(slv_aw_id), aw_st, aw_m);
         predict(1, int'(slv_ar_id), ar_st, ar_m);
         aw_go = rst_ni && slv_aw_valid && !aw_st;
         ar_go = rst_ni && slv_ar_valid && !ar_st;
         check($sformatf("rnd%0d mst_aw_valid", c), mst_aw_valid, aw_go);
         check($sformatf("rnd%0d slv_aw_ready", c), slv_aw_ready, rst_ni && mst_aw_ready && !aw_st);
         if (aw_go) check($sformatf("rnd%0d mst_aw_id", c), mst_aw_id, aw_m);
         check($sformatf("rnd%0d mst_ar_valid", c), mst_ar_valid, ar_go);
         check($sformatf("rnd%0d slv_ar_ready", c), slv_ar_ready, rst_ni && mst_ar_ready && !ar_st);
         if (ar_go) check($sformatf("rnd%0d mst_ar_id", c), mst_ar_id, ar_m);
         if (mst_b_valid) begin
            es = owner(0, int'(mst_b_id));
            check($sformatf("rnd%0d slv_b_id", c), slv_b_id, (es < 0) ? 0 : es);
         end
         if (mst_r_valid) begin
            es = owner(1, int'(mst_r_id));
            check($sformatf("rnd%0d slv_r_id", c), slv_r_id, (es < 0) ? 0 : es);
         end
         if (c % 64 == 0) begin
            check($sformatf("rnd%0d mst_ar_pld", c), mst_ar_pld, slv_ar_pld);
            check($sformatf("rnd%0d mst_w_data", c), mst_w_data, slv_w_data);
            check($sformatf("rnd%0d slv_r_data", c), slv_r_data, mst_r_data);
            check($sformatf("rnd%0d slv_r_user", c), slv_r_user, 0);
         end
         @(posedge clk);
         if (!rst_ni) begin
            mid_of.delete();
            cnt_of.delete();
         end else begin
            apply(0, aw_go && mst_aw_ready, int'(slv_aw_id), aw_m, mst_b_valid && slv_b_ready, int'(mst_b_id));
            apply(1, ar_go && mst_ar_ready, int'(slv_ar_id), ar_m,
                  mst_r_valid && slv_r_ready && mst_r_last, int'(mst_r_id));
         end
         #1;
      end
      rst_ni = 1'b1;
   endtask

   initial begin
      vecs[0]  = v_ar(6'h21, 4'd0);
      vecs[1]  = v_ar(6'h05, 4'd1);
      vecs[2]  = v_ar(6'h3F, 4'd2);
      vecs[3]  = v_r(4'd2, 1'b0, 6'h3F);
      vecs[4]  = v_r(4'd2, 1'b1, 6'h3F);
      vecs[5]  = v_r(4'd0, 1'b1, 6'h21);
      vecs[6]  = v_r(4'd1, 1'b1, 6'h05);
      vecs[7]  = v_ar(6'h07, 4'd0);
      vecs[8]  = v_r(4'd0, 1'b1, 6'h07);
      vecs[9]  = v_aw(6'h10, 4'd0);
      vecs[10] = v_aw(6'h10, 4'd0);
      vecs[11] = v_aw(6'h10, 4'd0);
      vecs[12] = v_b(4'd0, 6'h10);
      vecs[13] = v_b(4'd0, 6'h10);
      vecs[14] = v_aw(6'h12, 4'd1);
      vecs[15] = v_b(4'd0, 6'h10);
      vecs[16] = v_aw(6'h10, 4'd0);
      vecs[17] = v_b(4'd0, 6'h10);
      vecs[18] = v_b(4'd1, 6'h12);
      vecs[19] = v_aw(6'h33, 4'd0);
      vecs[20] = v_b(4'd0, 6'h33);

      rst_ni = 1'b0;
      slv_aw_valid = 0; slv_aw_id = 0; slv_aw_pld = 0; slv_w_valid = 0; slv_w_data = 0;
      slv_w_strb = 0; slv_w_last = 0; slv_b_ready = 0; slv_ar_valid = 0; slv_ar_id = 0;
      slv_ar_pld = 0; slv_r_ready = 0; mst_aw_ready = 0; mst_w_ready = 0; mst_b_valid = 0;
      mst_b_id = 0; mst_b_resp = 0; mst_ar_ready = 0; mst_r_valid = 0; mst_r_id = 0;
      mst_r_data = 0; mst_r_resp = 0; mst_r_last = 0;

      // Reset state with all inputs low, then again just after release.
      repeat (2) tick();
      for (int p = 0; p < 2; p++) begin
         sample();
         check($sformatf("rst%0d mst_aw_valid", p), mst_aw_valid, 0);
         check($sformatf("rst%0d mst_ar_valid", p), mst_ar_valid, 0);
         check($sformatf("rst%0d slv_aw_ready", p), slv_aw_ready, 0);
         check($sformatf("rst%0d slv_ar_ready", p), slv_ar_ready, 0);
         check($sformatf("rst%0d slv_b_valid", p), slv_b_valid, 0);
         check($sformatf("rst%0d slv_r_valid", p), slv_r_valid, 0);
         check($sformatf("rst%0d mst_aw_id", p), mst_aw_id, 0);
         check($sformatf("rst%0d mst_ar_id", p), mst_ar_id, 0);
         check($sformatf("rst%0d slv_b_id", p), slv_b_id, 0);
         check($sformatf("rst%0d slv_r_id", p), slv_r_id, 0);
         tick();
         rst_ni = 1'b1;
      end

      // Distinct IDs, out-of-order R, same-ID reuse.
      for (int i = 0; i < NV; i++) begin
         set_in(vecs[i].aw_v, vecs[i].aw_id, vecs[i].b_v, vecs[i].b_mid, vecs[i].ar_v,
                vecs[i].ar_id, vecs[i].r_v, vecs[i].r_mid, vecs[i].r_last);
         sample();
         if (vecs[i].aw_v) begin
            check($sformatf("vec%0d mst_aw_valid", i), mst_aw_valid, 1);
            check($sformatf("vec%0d slv_aw_ready", i), slv_aw_ready, 1);
            check($sformatf("vec%0d mst_aw_id", i), mst_aw_id, vecs[i].e_mid);
         end
         if (vecs[i].ar_v) begin
            check($sformatf("vec%0d mst_ar_valid", i), mst_ar_valid, 1);
            check($sformatf("vec%0d slv_ar_ready", i), slv_ar_ready, 1);
            check($sformatf("vec%0d mst_ar_id", i), mst_ar_id, vecs[i].e_mid);
         end
         if (vecs[i].b_v) check($sformatf("vec%0d slv_b_id", i), slv_b_id, vecs[i].e_sid);
         if (vecs[i].r_v) check($sformatf("vec%0d slv_r_id", i), slv_r_id, vecs[i].e_sid);
         tick();
      end

      // Table full: 16 distinct reads, the 17th waits for a slot to retire.
      for (int k = 0; k < 16; k++) begin
         set_in(1'b0, 6'h0, 1'b0, 4'h0, 1'b1, 6'(32'h20 + k), 1'b0, 4'h0, 1'b0);
         sample();
         check($sformatf("full ar%0d valid", k), mst_ar_valid, 1);
         check($sformatf("full ar%0d id", k), mst_ar_id, k);
         tick();
      end
      set_in(1'b0, 6'h0, 1'b0, 4'h0, 1'b1, 6'h30, 1'b0, 4'h0, 1'b0);
      sample();
      check("full 17th arready", slv_ar_ready, 0);
      check("full 17th arvalid", mst_ar_valid, 0);
      tick();
      set_in(1'b0, 6'h0, 1'b0, 4'h0, 1'b1, 6'h30, 1'b1, 4'd7, 1'b1);
      sample();
      check("full freeing-cycle arvalid", mst_ar_valid, 0);
      check("full freeing rid", slv_r_id, 6'h27);
      tick();
      set_in(1'b0, 6'h0, 1'b0, 4'h0, 1'b1, 6'h30, 1'b0, 4'h0, 1'b0);
      sample();
      check("full 17th issued", mst_ar_valid, 1);
      check("full 17th arid", mst_ar_id, 7);
      tick();
      for (int k = 0; k < 16; k++) begin
         set_in(1'b0, 6'h0, 1'b0, 4'h0, 1'b0, 6'h0, 1'b1, 4'(k), 1'b1);
         sample();
         check($sformatf("full drain rid%0d", k), slv_r_id, (k == 7) ? 32'h30 : 32'h20 + k);
         tick();
      end

      // Per-ID saturation: the 9th write on one ID waits for a B.
      for (int k = 0; k < 8; k++) begin
         set_in(1'b1, 6'h2A, 1'b0, 4'h0, 1'b0, 6'h0, 1'b0, 4'h0, 1'b0);
         sample();
         check($sformatf("sat aw%0d valid", k), mst_aw_valid, 1);
         check($sformatf("sat aw%0d id", k), mst_aw_id, 0);
         tick();
      end
      set_in(1'b1, 6'h2A, 1'b0, 4'h0, 1'b0, 6'h0, 1'b0, 4'h0, 1'b0);
      sample();
      check("sat 9th awready", slv_aw_ready, 0);
      check("sat 9th awvalid", mst_aw_valid, 0);
      tick();
      set_in(1'b1, 6'h2A, 1'b1, 4'd0, 1'b0, 6'h0, 1'b0, 4'h0, 1'b0);
      sample();
      check("sat B-cycle awvalid", mst_aw_valid, 0);
      check("sat B-cycle bid", slv_b_id, 6'h2A);
      tick();
      set_in(1'b1, 6'h2A, 1'b0, 4'h0, 1'b0, 6'h0, 1'b0, 4'h0, 1'b0);
      sample();
      check("sat 9th issued", mst_aw_valid, 1);
      check("sat 9th awid", mst_aw_id, 0);
      tick();
      for (int k = 0; k < 8; k++) begin
         set_in(1'b0, 6'h0, 1'b1, 4'd0, 1'b0, 6'h0, 1'b0, 4'h0, 1'b0);
         sample();
         check($sformatf("sat drain bid%0d", k), slv_b_id, 6'h2A);
         tick();
      end

      // Completion to zero and re-request of the same SoC ID in one cycle.
      for (int k = 0; k < 4; k++) begin
         set_in(1'b1, 6'(k + 1), 1'b0, 4'h0, 1'b0, 6'h0, 1'b0, 4'h0, 1'b0);
         sample();
         check($sformatf("sim aw%0d id", k), mst_aw_id, k);
         tick();
      end
      set_in(1'b1, 6'h04, 1'b1, 4'd3, 1'b0, 6'h0, 1'b0, 4'h0, 1'b0);
      sample();
      check("sim same-cycle awid", mst_aw_id, 3);
      check("sim same-cycle bid", slv_b_id, 6'h04);
      tick();
      set_in(1'b1, 6'h3E, 1'b1, 4'd3, 1'b0, 6'h0, 1'b0, 4'h0, 1'b0);
      sample();
      check("sim entry3 still valid bid", slv_b_id, 6'h04);
      check("sim new sid skips entry3", mst_aw_id, 4);
      tick();
      set_in(1'b1, 6'h3D, 1'b0, 4'h0, 1'b0, 6'h0, 1'b0, 4'h0, 1'b0);
      sample();
      check("sim entry3 reused", mst_aw_id, 3);
      tick();
      for (int k = 0; k < 5; k++) begin
         set_in(1'b0, 6'h0, 1'b1, 4'(k), 1'b0, 6'h0, 1'b0, 4'h0, 1'b0);
         sample();
         check($sformatf("sim drain bid%0d", k), slv_b_id, (k == 3) ? 32'h3D : (k == 4) ? 32'h3E : k + 1);
         tick();
      end

      // Reset with four reads outstanding drops all tracking.
      for (int k = 0; k < 4; k++) begin
         set_in(1'b0, 6'h0, 1'b0, 4'h0, 1'b1, 6'(32'h11 + k), 1'b0, 4'h0, 1'b0);
         sample();
         check($sformatf("rst-mid ar%0d id", k), mst_ar_id, k);
         tick();
      end
      set_in(1'b1, 6'h15, 1'b0, 4'h0, 1'b1, 6'h15, 1'b0, 4'h0, 1'b0);
      rst_ni = 1'b0;
      sample();
      check("rst-mid arready", slv_ar_ready, 0);
      check("rst-mid arvalid", mst_ar_valid, 0);
      check("rst-mid awready", slv_aw_ready, 0);
      tick();
      rst_ni = 1'b1;
      set_in(1'b0, 6'h0, 1'b0, 4'h0, 1'b1, 6'h15, 1'b0, 4'h0, 1'b0);
      sample();
      check("rst-mid next arvalid", mst_ar_valid, 1);
      check("rst-mid next arid", mst_ar_id, 0);
      tick();
      set_in(1'b0, 6'h0, 1'b0, 4'h0, 1'b0, 6'h0, 1'b1, 4'd0, 1'b1);
      sample();
      check("rst-mid rid", slv_r_id, 6'h15);
      tick();
      set_in(1'b0, 6'h0, 1'b0, 4'h0, 1'b0, 6'h0, 1'b0, 4'h0, 1'b0);
      tick();

      run_random(4000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
